// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: FSM encoding, default word
// width and parity-mode selectors.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DATA_W = 8;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/gexor.sv
// Generic two-input XOR cell.
module gexor (
  input  logic a,
  input  logic b,
  output logic y_c
);

  assign y_c = a ^ b;

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit,
// stop bit; presents the word with parity and framing status.
module parity_rx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter bit          ODD_PARITY = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              perr,
  output logic              ferr,
  output logic              busy
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   sreg;
  logic                acc;
  logic                acc_nxt_c;
  logic                perr_q;

  // Running parity: the same XOR serves data accumulation and the parity check.
  gexor u_acc_xor (
    .a   (acc),
    .b   (sin),
    .y_c (acc_nxt_c)
  );

  // Frame FSM; every transition waits for a bit strobe, valid self-clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sreg   <= '0;
      acc    <= 1'b0;
      perr_q <= 1'b0;
      dout   <= '0;
      valid  <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (en) begin
        case (state)
          ST_IDLE: begin
            if (!sin) begin
              state <= ST_DATA;
              cnt   <= '0;
              acc   <= 1'b0;
              busy  <= 1'b1;
            end
          end
          ST_DATA: begin
            sreg <= {sin, sreg[DATA_W-1:1]};
            acc  <= acc_nxt_c;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            perr_q <= acc_nxt_c ^ ODD_PARITY;
            state  <= ST_STOP;
          end
          ST_STOP: begin
            dout  <= sreg;
            perr  <= perr_q;
            ferr  <= ~sin;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_rx.sv
// Self-checking bench for parity_rx: even and odd parity instances share one
// serial stream and are compared against a frame-level reference model.
module tb_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       sin;
  logic [7:0] dout_e, dout_o;
  logic       valid_e, perr_e, ferr_e, busy_e;
  logic       valid_o, perr_o, ferr_o, busy_o;

  int tests = 0;
  int fails = 0;
  int vcnt_e = 0;
  int vcnt_o = 0;
  int frames_done = 0;
  logic [7:0] last_dout = 8'h00;
  logic       last_pe = 1'b0;
  logic       last_po = 1'b0;
  logic       last_fe = 1'b0;
  time        last_valid_t = 0;

  always #5 clk = ~clk;

  parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .en(en), .sin(sin),
    .dout(dout_e), .valid(valid_e), .perr(perr_e), .ferr(ferr_e), .busy(busy_e)
  );

  parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .en(en), .sin(sin),
    .dout(dout_o), .valid(valid_o), .perr(perr_o), .ferr(ferr_o), .busy(busy_o)
  );

  // Count clock cycles in which valid is high; each frame must add exactly one.
  always @(negedge clk) begin
    if (valid_e) vcnt_e++;
    if (valid_o) vcnt_o++;
  end

  task automatic drive_edge(input logic b);
    en  = 1'b1;
    sin = b;
    @(posedge clk);
    #1;
    en  = 1'b0;
    sin = 1'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      en  = 1'b0;
      sin = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // gap_mode: 0 = en held high, 1 = one idle clock before every bit, 2 = random idles
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int gap_mode, input string name);
    logic [10:0] bits;
    logic [23:0] got, exp;
    logic        exp_pe, exp_po;
    bits = {stop, pbit, d, 1'b0};
    exp_pe = 1'(($countones(d) + int'(pbit)) % 2);
    exp_po = ~exp_pe;
    for (int i = 0; i < 11; i++) begin
      if (gap_mode == 1) gap(1);
      else if (gap_mode == 2) gap(int'($urandom_range(0, 2)));
      drive_edge(bits[i]);
      if (i == 0) begin
        got = {valid_e, busy_e, dout_e, perr_e, ferr_e, valid_o, busy_o, dout_o, perr_o, ferr_o};
        exp = {1'b0, 1'b1, last_dout, last_pe, last_fe, 1'b0, 1'b1, last_dout, last_po, last_fe};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL %s start got=%h exp=%h", name, got, exp);
        end
        tests++;
        if (vcnt_e !== frames_done || vcnt_o !== frames_done) begin
          fails++;
          $display("FAIL %s valid_cycles got=%0d/%0d exp=%0d", name, vcnt_e, vcnt_o, frames_done);
        end
      end else if (i == 9) begin
        tests++;
        if ({valid_e, busy_e, valid_o, busy_o} !== 4'b0101) begin
          fails++;
          $display("FAIL %s pre_stop got=%b exp=0101", name, {valid_e, busy_e, valid_o, busy_o});
        end
      end else if (i == 10) begin
        got = {valid_e, busy_e, dout_e, perr_e, ferr_e, valid_o, busy_o, dout_o, perr_o, ferr_o};
        exp = {1'b1, 1'b0, d, exp_pe, ~stop, 1'b1, 1'b0, d, exp_po, ~stop};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL %s stop got=%h exp=%h", name, got, exp);
        end
        frames_done++;
        last_dout    = d;
        last_pe      = exp_pe;
        last_po      = exp_po;
        last_fe      = ~stop;
        last_valid_t = $time;
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] got;
    rst_n = 1'b0;
    en    = 1'b0;
    sin   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {valid_e, busy_e, dout_e, perr_e, ferr_e, valid_o, busy_o, dout_o, perr_o, ferr_o};
    tests++;
    if (got !== 24'h0) begin
      fails++;
      $display("FAIL reset_values got=%h exp=000000", got);
    end
    rst_n = 1'b1;
    gap(1);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 1'b1, 0, "even_a5");
    gap(1);
    send_frame(8'hA5, 1'b1, 1'b1, 0, "bad_par_a5");
    gap(1);
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0, 0, "ferr_3c");
    drive_edge(1'b1);
    tests++;
    if ({valid_e, busy_e, valid_o, busy_o} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_after_ferr got=%b exp=0000", {valid_e, busy_e, valid_o, busy_o});
    end
  endtask

  task automatic test_en_toggle();
    send_frame(8'h5A, 1'b0, 1'b1, 1, "en_toggle_5a");
    gap(2);
  endtask

  task automatic test_mid_reset();
    logic [23:0] got;
    drive_edge(1'b0);
    repeat (4) drive_edge(1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    got = {valid_e, busy_e, dout_e, perr_e, ferr_e, valid_o, busy_o, dout_o, perr_o, ferr_o};
    tests++;
    if (got !== 24'h0) begin
      fails++;
      $display("FAIL async_reset got=%h exp=000000", got);
    end
    last_dout = 8'h00;
    last_pe   = 1'b0;
    last_po   = 1'b0;
    last_fe   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(1);
    send_frame(8'h01, 1'b1, 1'b1, 0, "after_reset_01");
    gap(1);
  endtask

  task automatic test_back_to_back();
    time t1;
    send_frame(8'h00, 1'b0, 1'b1, 0, "b2b_00");
    t1 = last_valid_t;
    send_frame(8'hFF, 1'b0, 1'b1, 0, "b2b_ff");
    tests++;
    if (last_valid_t - t1 !== 110) begin
      fails++;
      $display("FAIL b2b_spacing got=%0t exp=110", last_valid_t - t1);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       pbit, stop;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      pbit = 1'($countones(d) % 2) ^ 1'($urandom_range(0, 3) == 0);
      stop = 1'($urandom_range(0, 4) != 0);
      repeat (int'($urandom_range(0, 2))) drive_edge(1'b1);
      send_frame(d, pbit, stop, 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_framing();
    test_en_toggle();
    test_mid_reset();
    test_back_to_back();
    test_random();
    gap(2);
    tests++;
    if (vcnt_e !== frames_done || vcnt_o !== frames_done) begin
      fails++;
      $display("FAIL final_valid_cycles got=%0d/%0d exp=%0d", vcnt_e, vcnt_o, frames_done);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
